// File: rtl/mii_tx_arbiter.sv
// Round-robin owner of the TX byte lane: frames each granted packet as START, payload, TERMINATE, IPG idles.
// One cycle from accepted byte to o_txd; o_ready follows the grant only in DATA, underrun inserts ERROR codes.
module mii_tx_arbiter #(
    parameter int          NUM_SRC        = 4,
    parameter int          IPG_LEN        = 12,
    parameter logic [7:0]  IDLE_CODE      = 8'h07,
    parameter logic [7:0]  START_CODE     = 8'hFB,
    parameter logic [7:0]  TERMINATE_CODE = 8'hFD,
    parameter logic [7:0]  ERROR_CODE     = 8'hFE
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic [NUM_SRC-1:0]     i_valid,
    input  logic [NUM_SRC*8-1:0]   i_data,
    input  logic [NUM_SRC-1:0]     i_last,
    output logic [NUM_SRC-1:0]     o_ready,
    output logic [7:0]             o_txd,
    output logic                   o_txc,
    output logic [NUM_SRC-1:0]     o_grant,
    output logic                   o_busy,
    output logic [15:0]            o_frame_cnt,
    output logic [15:0]            o_err_cnt
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_TERM, S_IPG} state_t;

    state_t               state;
    logic [IW-1:0]        last_grant;
    logic [IW-1:0]        sel_idx;
    logic [NUM_SRC-1:0]   sel_oh;
    logic                 sel_any;
    logic                 g_vld;
    logic                 g_last;
    logic [7:0]           g_dat;
    logic [7:0]           gap_cnt;

    // Scan from the farthest offset back toward last_grant+1 so the nearest requester wins.
    always_comb begin
        int idx;
        idx     = 0;
        sel_any = 1'b0;
        sel_idx = last_grant;
        sel_oh  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_SRC;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (s == idx && i_valid[s]) begin
                    sel_any = 1'b1;
                    sel_idx = IW'(s);
                    sel_oh  = NUM_SRC'(1) << s;
                end
            end
        end
    end

    always_comb begin
        g_dat = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            g_dat = g_dat | (i_data[8*s +: 8] & {8{o_grant[s]}});
        end
        g_vld  = |(i_valid & o_grant);
        g_last = |(i_last & o_grant);
    end

    assign o_ready = (state == S_DATA) ? o_grant : '0;
    assign o_busy  = (state != S_IDLE);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_txd       <= IDLE_CODE;
            o_txc       <= 1'b1;
            o_grant     <= '0;
            last_grant  <= IW'(NUM_SRC - 1);
            gap_cnt     <= '0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_txc <= 1'b1;
                    if (i_enable && sel_any) begin
                        o_grant    <= sel_oh;
                        last_grant <= sel_idx;
                        o_txd      <= START_CODE;
                        state      <= S_DATA;
                    end else begin
                        o_txd <= IDLE_CODE;
                    end
                end
                S_DATA: begin
                    if (g_vld) begin
                        o_txd <= g_dat;
                        o_txc <= 1'b0;
                        if (g_last) begin
                            state <= S_TERM;
                        end
                    end else begin
                        // Underrun: hold the frame open and mark the gap on the wire.
                        o_txd <= ERROR_CODE;
                        o_txc <= 1'b1;
                        if (o_err_cnt != 16'hFFFF) begin
                            o_err_cnt <= o_err_cnt + 16'd1;
                        end
                    end
                end
                S_TERM: begin
                    o_txd       <= TERMINATE_CODE;
                    o_txc       <= 1'b1;
                    o_frame_cnt <= o_frame_cnt + 16'd1;
                    o_grant     <= '0;
                    gap_cnt     <= '0;
                    state       <= S_IPG;
                end
                S_IPG: begin
                    o_txd <= IDLE_CODE;
                    o_txc <= 1'b1;
                    if (gap_cnt == 8'(IPG_LEN - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Bench for mii_tx_arbiter: cycle vectors for single frames, wire-stream model for arbitration and underrun.
module tb_mii_tx_arbiter;

    localparam int N   = 4;
    localparam int IPG = 12;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_enable;
    logic [N-1:0]  i_valid;
    logic [N*8-1:0] i_data;
    logic [N-1:0]  i_last;
    logic [N-1:0]  o_ready;
    logic [7:0]    o_txd;
    logic          o_txc;
    logic [N-1:0]  o_grant;
    logic          o_busy;
    logic [15:0]   o_frame_cnt;
    logic [15:0]   o_err_cnt;

    always #5 clk = ~clk;

    mii_tx_arbiter #(
        .NUM_SRC(N), .IPG_LEN(IPG), .IDLE_CODE(8'h07), .START_CODE(8'hFB),
        .TERMINATE_CODE(8'hFD), .ERROR_CODE(8'hFE)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid),
        .i_data(i_data), .i_last(i_last), .o_ready(o_ready), .o_txd(o_txd),
        .o_txc(o_txc), .o_grant(o_grant), .o_busy(o_busy),
        .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  lst;
        logic [7:0]  txd;
        logic        txc;
        logic [3:0]  rdy;
        logic [3:0]  gnt;
        logic        busy;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic [3:0] vld, input logic [31:0] dat,
                                input logic [3:0] lst, input logic [7:0] txd, input logic txc,
                                input logic [3:0] rdy, input logic [3:0] gnt, input logic busy,
                                input logic [15:0] fc);
        vec_t v;
        v.en = en; v.vld = vld; v.dat = dat; v.lst = lst; v.txd = txd; v.txc = txc;
        v.rdy = rdy; v.gnt = gnt; v.busy = busy; v.fc = fc;
        return v;
    endfunction

    // Frame store: per source, up to 4 frames of up to 8 bytes, each byte preceded by gap underrun cycles.
    int          nfrm[N];
    int          flen[N][4];
    logic [7:0]  fdat[N][4][8];
    int          fgap[N][4][8];

    task automatic clear_frames();
        for (int s = 0; s < N; s++) nfrm[s] = 0;
    endtask

    task automatic add_frame(input int s, input int len, input logic [7:0] base,
                             input int gpos, input int gval);
        int f;
        f = nfrm[s];
        flen[s][f] = len;
        for (int b = 0; b < len; b++) begin
            fdat[s][f][b] = base + 8'(b);
            fgap[s][f][b] = (b == gpos) ? gval : 0;
        end
        nfrm[s] = f + 1;
    endtask

    task automatic run_stream(input string nm, input int dis);
        logic [8:0] exq[$];
        logic [8:0] obs[$];
        int cnt[N];
        int fi[N], bi[N], gr[N];
        logic pr[N], pv[N];
        int last, s, f, total, exp_err, budget, lim, bad0;
        bit started;

        @(negedge clk);
        i_rst = 1'b1; i_enable = 1'b0; i_valid = '0; i_last = '0; i_data = '0;
        @(negedge clk);
        i_rst = 1'b0;

        // Expected wire: frames served round-robin among sources that still hold frames.
        last = N - 1; total = 0; exp_err = 0;
        for (int k = 0; k < N; k++) begin cnt[k] = 0; total += nfrm[k]; end
        for (int t = 0; t < total; t++) begin
            s = -1;
            for (int k = 1; k <= N && s < 0; k++)
                if (cnt[(last + k) % N] < nfrm[(last + k) % N]) s = (last + k) % N;
            last = s; f = cnt[s]; cnt[s]++;
            exq.push_back({1'b1, 8'hFB});
            for (int b = 0; b < flen[s][f]; b++) begin
                for (int g = 0; g < fgap[s][f][b]; g++) exq.push_back({1'b1, 8'hFE});
                exp_err += fgap[s][f][b];
                exq.push_back({1'b0, fdat[s][f][b]});
            end
            exq.push_back({1'b1, 8'hFD});
            for (int g = 0; g < IPG; g++) exq.push_back({1'b1, 8'h07});
        end

        for (int k = 0; k < N; k++) begin
            fi[k] = 0; bi[k] = 0; pr[k] = 1'b0; pv[k] = 1'b0;
            gr[k] = (nfrm[k] > 0) ? fgap[k][0][0] : 0;
        end
        started = 1'b0;
        budget = exq.size() + dis + 100;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (cyc < dis)
                chk($sformatf("%s_disabled_idle[%0d]", nm, cyc), {o_txd, o_txc, o_ready}, {8'h07, 1'b1, 4'b0});
            if (o_txc && o_txd == 8'hFB) started = 1'b1;
            if (started) obs.push_back({o_txc, o_txd});
            if (obs.size() >= exq.size()) break;
            for (int k = 0; k < N; k++) begin
                if (pr[k] && pv[k]) begin
                    bi[k]++;
                    if (bi[k] == flen[k][fi[k]]) begin fi[k]++; bi[k] = 0; end
                    if (fi[k] < nfrm[k]) gr[k] = fgap[k][fi[k]][bi[k]];
                end else if (pr[k]) begin
                    gr[k]--;
                end
                if (fi[k] >= nfrm[k]) begin
                    pv[k] = 1'b0;
                    i_last[k] = 1'b0;
                end else begin
                    pv[k] = !(o_ready[k] && gr[k] > 0);
                    i_data[8*k +: 8] = fdat[k][fi[k]][bi[k]];
                    i_last[k] = (bi[k] == flen[k][fi[k]] - 1);
                end
                i_valid[k] = pv[k];
                pr[k] = o_ready[k];
            end
            i_enable = (cyc >= dis);
        end
        i_valid = '0; i_last = '0;

        chk({nm, "_stream_len"}, obs.size(), exq.size());
        lim = (obs.size() < exq.size()) ? obs.size() : exq.size();
        for (int i = 0; i < lim; i++) begin
            bad0 = n_bad;
            chk($sformatf("%s_wire[%0d]", nm, i), obs[i], exq[i]);
            if (n_bad != bad0) break;
        end
        chk({nm, "_frame_cnt"}, o_frame_cnt, total);
        chk({nm, "_err_cnt"}, o_err_cnt, exp_err);
    endtask

    initial begin
        i_rst = 1'b0; i_enable = 1'b0; i_valid = '0; i_data = '0; i_last = '0;
        #1 i_rst = 1'b1;
        #1;
        chk("reset_state", {o_txd, o_txc, o_grant, o_ready, o_busy, o_frame_cnt, o_err_cnt},
            {8'h07, 1'b1, 4'b0, 4'b0, 1'b0, 16'd0, 16'd0});
        @(negedge clk);
        i_rst = 1'b0;

        // Source 0 four-byte frame, then a single-byte frame from source 2.
        tbl.push_back(mk(1, 4'b0001, 32'h11, 0, 8'hFB, 1, 4'b0001, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 4'b0001, 32'h11, 0, 8'h11, 0, 4'b0001, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 4'b0001, 32'h22, 0, 8'h22, 0, 4'b0001, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 4'b0001, 32'h33, 0, 8'h33, 0, 4'b0001, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 4'b0001, 32'h44, 4'b0001, 8'h44, 0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 32'h0, 0, 8'hFD, 1, 4'b0000, 4'b0000, 1, 1));
        for (int i = 0; i < IPG; i++)
            tbl.push_back(mk(1, 4'b0000, 32'h0, 0, 8'h07, 1, 4'b0000, 4'b0000, (i != IPG - 1), 1));
        tbl.push_back(mk(1, 4'b0100, 32'h00AB0000, 4'b0100, 8'hFB, 1, 4'b0100, 4'b0100, 1, 1));
        tbl.push_back(mk(1, 4'b0100, 32'h00AB0000, 4'b0100, 8'hAB, 0, 4'b0000, 4'b0100, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 32'h0, 0, 8'hFD, 1, 4'b0000, 4'b0000, 1, 2));
        for (int i = 0; i < IPG; i++)
            tbl.push_back(mk(1, 4'b0000, 32'h0, 0, 8'h07, 1, 4'b0000, 4'b0000, (i != IPG - 1), 2));

        foreach (tbl[i]) begin
            @(negedge clk);
            i_enable = tbl[i].en; i_valid = tbl[i].vld; i_data = tbl[i].dat; i_last = tbl[i].lst;
            @(posedge clk);
            #1;
            chk($sformatf("vec[%0d] txd/txc/rdy/gnt/busy/fcnt", i),
                {o_txd, o_txc, o_ready, o_grant, o_busy, o_frame_cnt},
                {tbl[i].txd, tbl[i].txc, tbl[i].rdy, tbl[i].gnt, tbl[i].busy, tbl[i].fc});
        end

        clear_frames();
        for (int s = 0; s < N; s++)
            for (int f = 0; f < 2; f++) add_frame(s, 2, 8'(s * 64 + f * 16), -1, 0);
        run_stream("rr", 0);

        clear_frames();
        add_frame(2, 5, 8'hA1, 2, 3);
        run_stream("underrun", 0);

        clear_frames();
        add_frame(1, 3, 8'h51, -1, 0);
        add_frame(3, 3, 8'h71, -1, 0);
        run_stream("enable", 20);

        for (int r = 0; r < 3; r++) begin
            clear_frames();
            for (int s = 0; s < N; s++) begin
                int nf;
                nf = $urandom_range(1, 4);
                for (int f = 0; f < nf; f++) begin
                    add_frame(s, $urandom_range(1, 6), 8'($urandom_range(0, 255)), -1, 0);
                    for (int b = 0; b < flen[s][f]; b++) begin
                        fdat[s][f][b] = 8'($urandom_range(0, 255));
                        fgap[s][f][b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                    end
                end
            end
            run_stream($sformatf("random%0d", r), 0);
        end

        // Reset while a frame is on the wire; counters are non-zero going in.
        @(negedge clk);
        i_enable = 1'b1; i_valid = 4'b0001; i_last = '0; i_data = 32'h11;
        @(posedge clk); #1;
        chk("rst_seq_start", {o_txd, o_txc}, {8'hFB, 1'b1});
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk); i_data = 32'h22;
        @(posedge clk); #1;
        @(negedge clk); i_data = 32'h33;
        @(posedge clk); #1;
        chk("rst_seq_byte3", {o_txd, o_txc}, {8'h33, 1'b0});
        #2 i_rst = 1'b1;
        #1;
        chk("rst_midframe_state", {o_txd, o_txc, o_grant, o_ready, o_busy, o_frame_cnt, o_err_cnt},
            {8'h07, 1'b1, 4'b0, 4'b0, 1'b0, 16'd0, 16'd0});
        @(negedge clk);
        i_rst = 1'b0; i_valid = 4'b0101; i_data = 32'h00CC00AA;
        @(posedge clk); #1;
        chk("rst_then_src0_first", {o_grant, o_txd, o_txc}, {4'b0001, 8'hFB, 1'b1});
        @(negedge clk);
        @(posedge clk); #1;
        chk("rst_then_src0_byte", {o_txd, o_txc}, {8'hAA, 1'b0});
        i_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mii_tx_arbiter.md
Name: mii_tx_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit MII/XGMII-lane transmit byte stream (TXD/TXC) among NUM_SRC payload sources.
- Frames each granted packet: START code, payload bytes (ctrl=0), TERMINATE code, then a programmable inter-packet gap of IDLE codes.
- Sits between the frame/payload generators and the PCS encoder. It is the single owner of the TX lane's control characters.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- IPG_LEN, 12, number of IDLE bytes forced between TERMINATE and the next START (1..255).
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- TERMINATE_CODE, 8'hFD, terminate control character.
- ERROR_CODE, 8'hFE, error control character emitted on underrun.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_enable  in  1  allow new grants; a frame already in progress always completes.
- i_valid  in  NUM_SRC  per-source payload byte valid; also acts as the frame request.
- i_data  in  NUM_SRC*8  per-source payload byte; source n uses bits [8n+7:8n].
- i_last  in  NUM_SRC  per-source last payload byte of the frame.
- o_ready  out  NUM_SRC  per-source byte accept (combinational from state and grant).
- o_txd  out  8  registered TXD byte.
- o_txc  out  1  registered TXC (1 = control character).
- o_grant  out  NUM_SRC  one-hot registered current owner; all zero when no owner.
- o_busy  out  1  high in DATA, TERM and IPG.
- o_frame_cnt  out  16  frames terminated; wraps.
- o_err_cnt  out  16  underrun cycles; saturates at 16'hFFFF.

Behaviour:
- Reset (async, immediate): o_txd=IDLE_CODE, o_txc=1, o_grant=0, o_ready=0, o_busy=0, counters=0, state=IDLE, last_grant=NUM_SRC-1 (source 0 has first priority).
- States: IDLE, DATA, TERM, IPG. o_txd/o_txc are loaded every cycle with the value listed for the current state.
- IDLE:
  - If i_enable and any i_valid: select the first requester scanning from (last_grant+1) mod NUM_SRC upward, with wrap-around.
  - Load o_grant and last_grant with the selected source, load START_CODE/1, go to DATA.
  - Otherwise load IDLE_CODE/1.
  - o_ready=0 in this state.
- DATA:
  - o_ready[g]=1 for the granted source g only.
  - If i_valid[g]: load i_data[g]/0. If i_last[g], go to TERM.
  - If !i_valid[g] (underrun): load ERROR_CODE/1, increment o_err_cnt (saturating), stay in DATA. The frame resumes when valid returns. No timeout.
- TERM:
  - o_ready=0. Load TERMINATE_CODE/1, increment o_frame_cnt, clear the gap counter, go to IPG.
- IPG:
  - Load IDLE_CODE/1 and count IPG_LEN cycles, then go to IDLE.
  - o_grant clears on entry to IPG.
- Latency: a byte accepted in cycle t appears on o_txd in cycle t+1. The START byte appears in the cycle after the grant decision.
- Minimum wire sequence between packets: FD, IPG_LEN×07, FB. This holds back-to-back regardless of which source is served.
- A single-byte frame (i_last with the first byte) gives FB, byte, FD.
- i_enable low in IDLE: no grant, idles continue. Deasserting i_enable mid-frame does not affect the frame.
- Non-granted sources always see o_ready=0. i_data/i_last of non-granted sources are ignored.
- Reset mid-frame: the wire returns to idle at once. No TERMINATE is emitted and the partial frame is dropped.

Test Plan:
- Single source 0: 4 bytes 11,22,33,44 (last on 44), IPG_LEN=12 -> o_txd/o_txc = FB/1,11/0,22/0,33/0,44/0,FD/1, then 12×07/1; o_frame_cnt=1.
- All 4 sources valid continuously, 2-byte frames -> grant order 0,1,2,3,0,…; exactly 12 idles between each FD and FB; o_frame_cnt=8 after 8 frames.
- Source 2 drops i_valid for 3 cycles after byte 2 of 5 -> three FE/1 bytes inserted between byte 2 and byte 3; o_err_cnt=3; frame then ends with FD normally.
- i_enable=0 with sources 1 and 3 valid -> continuous 07/1, o_ready=0; raise i_enable -> source 1 is granted first, then source 3.
- Assert i_rst during payload byte 3 -> same cycle o_txd=07, o_txc=1, o_grant=0, counters=0; after release, source 0 has first priority.
- Single-byte frame (i_valid&i_last with AB) -> FB, AB/0, FD; o_ready high for exactly one cycle.
